pulse_train_gen: RTL and testbench
==================================

// Module: pulse_train_gen
//
// PURPOSE
//  Emits a programmed burst of rectangular pulses on a single-bit output: N pulses,
//  each high for HIGH_LEN cycles and low for LOW_LEN cycles. It is the transmit-side
//  counterpart of posedge_counter; every pulse is one clean rising edge for that
//  counter. Used for on-board self-test of the edge-counting path and as a
//  programmable trigger source, driven by the control register block.
//
// PARAMETERS
//  CNT_W   16  width of pulse-count config and sent counter (matches posedge_counter.cnt)
//  TIME_W  16  width of high/low phase length config, in clk cycles
//
// PORTS
//  clk        in   1       system clock, all logic on rising edge
//  rst_n      in   1       asynchronous active-low reset
//  start      in   1       request a burst; sampled on clk rising edge
//  abort      in   1       terminate burst; sampled on clk rising edge
//  n_pulses   in   CNT_W   number of pulses in the burst; latched when start is accepted
//  high_len   in   TIME_W  high-phase cycles; 0 is treated as 1; latched when start is accepted
//  low_len    in   TIME_W  low-phase cycles; 0 is treated as 1; latched when start is accepted
//  busy       out  1       burst in progress (state HIGH or LOW)
//  done       out  1       one-cycle strobe on normal burst completion
//  out        out  1       pulse output, registered, glitch-free
//  sent       out  CNT_W   rising edges emitted in the current/last burst
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; out=0, busy=0, done=0, sent=0.
//    Latched config cleared to 0.
//  - All outputs are registered. Config is captured only on start acceptance.
//    Input changes mid-burst have no effect.
//  - FSM states: IDLE, HIGH, LOW, DONE.
//    IDLE: start=1 & abort=0 -> latch config, sent<=0.
//      n_pulses!=0 -> HIGH next edge.
//      n_pulses==0 -> DONE.
//    HIGH: out=1 for exactly max(high_len,1) cycles, then -> LOW.
//      sent increments on the edge that enters HIGH.
//    LOW: out=0 for exactly max(low_len,1) cycles.
//      Then -> HIGH if sent<n_pulses, else -> DONE.
//      The low phase of the final pulse is always served.
//    DONE: done=1 for one cycle, busy=0, then -> IDLE.
//  - Latency: start sampled at edge E0 -> out=1 and busy=1 from E0+1.
//    Period = max(H,1) + max(L,1).
//    Burst length = N*period cycles; done is asserted in cycle N*period+1 after E0.
//  - start while state!=IDLE is ignored. No queueing, no restart.
//  - abort=1 in any state -> IDLE on next edge: out=0, busy=0, done=0, sent holds.
//    abort and start in the same cycle: abort wins, no burst starts.
//  - sent never exceeds n_pulses and never wraps; max N is 2^CNT_W-1.
//  - The phase counter loads (len-1) on phase entry and decrements.
//    The transition fires when it reads 0. It is TIME_W bits wide, with no overflow.
//  - Async reset mid-burst: out drops to 0 immediately, with no done.
//
// STRUCTURE
//  - Shared package pulse_gen_pkg holds:
//    state encoding localparams (IDLE/HIGH/LOW/DONE);
//    default CNT_W/TIME_W;
//    a min_one(len) helper for the zero-length rule.
//  - Sub-module phase_timer: TIME_W down-counter with a load port (value = max(len,1)-1),
//    count enable, and a registered zero flag. It is instantiated once and shared
//    by the HIGH and LOW phases.
//  - Top level holds the FSM, the config latch, the sent counter and the output registers.
//
// TESTING
//  1) Reset: hold rst_n=0 10 cycles, toggle start -> out=0, busy=0, done=0, sent=0 throughout.
//  2) N=3,H=2,L=3, start at E0 -> out=1 in cycles 1-2, 6-7, 11-12; busy cycles 1-15;
//     done=1 only at cycle 16; sent=3. posedge_counter in loopback (en=1) reads 3.
//  3) N=2,H=0,L=0 -> treated as H=L=1. out=1,0,1,0 in cycles 1-4; done at cycle 5; sent=2.
//  4) N=0, start -> out stays 0, busy stays 0, done=1 at cycle 1, sent=0.
//  5) N=5,H=4,L=4, abort at cycle 10 -> out=0 and busy=0 from cycle 11; done never asserted;
//     sent=2. A second start at cycle 8 is ignored. start with abort in the same cycle in IDLE -> no burst.
//  6) N=65535,H=1,L=1 -> sent reaches 65535 without wrap. done at cycle 131071.
//     Counter loopback reads 65535.

Source files
------------

// File: rtl/pulse_gen_pkg.sv
// Shared definitions for the pulse train generator.
//  - FSM state encodings (IDLE/HIGH/LOW/DONE)
//  - default counter widths
//  - min_one(): maps a zero phase length to one cycle
package pulse_gen_pkg;

  localparam int CNT_W_DEF  = 16;
  localparam int TIME_W_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HIGH = 2'd1;
  localparam logic [1:0] ST_LOW  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // A phase length of zero would otherwise give an empty phase and no edge.
  function automatic logic [31:0] min_one(input logic [31:0] len);
    logic [31:0] v;
    if (len == 32'd0) begin
      v = 32'd1;
    end else begin
      v = len;
    end
    return v;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter timing one HIGH or LOW phase; shared by both phases.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  i_load       load i_load_val (phase length minus one) on this edge
//  i_load_val   value to load
//  i_en         decrement enable; the count stops at zero
//  o_zero       registered flag, high while the count is zero
module phase_timer
  import pulse_gen_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [TIME_W-1:0] i_load_val,
  input  logic              i_en,
  output logic              o_zero
);

  logic [TIME_W-1:0] r_cnt;
  logic              r_zero;

  // Count register and its zero flag, kept in step so the FSM sees a registered flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
    end else if (i_load) begin
      r_cnt  <= i_load_val;
      r_zero <= (i_load_val == '0);
    end else if (i_en && !r_zero) begin
      r_cnt  <= r_cnt - TIME_W'(1'b1);
      r_zero <= (r_cnt == TIME_W'(1'b1));
    end
  end

  assign o_zero = r_zero;

endmodule

// File: rtl/pulse_train_gen.sv
// Programmable burst generator: n_pulses rectangular pulses, each high for
// max(high_len,1) cycles and low for max(low_len,1) cycles.
// Ports:
//  clk, rst_n   clock, async active-low reset
//  start        request a burst (accepted only in IDLE and without abort)
//  abort        return to IDLE on the next edge; sent holds its value
//  n_pulses     pulse count, latched on start acceptance
//  high_len     high-phase cycles, latched on start acceptance
//  low_len      low-phase cycles, latched on start acceptance
//  busy         burst in progress
//  done         one-cycle strobe on normal completion
//  out          registered pulse output
//  sent         rising edges emitted in the current/last burst
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W  = CNT_W_DEF,
  parameter int TIME_W = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  n_pulses,
  input  logic [TIME_W-1:0] high_len,
  input  logic [TIME_W-1:0] low_len,
  output logic              busy,
  output logic              done,
  output logic              out,
  output logic [CNT_W-1:0]  sent
);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_n;
  logic [TIME_W-1:0] r_high_m1;
  logic [TIME_W-1:0] r_low_m1;
  logic              r_out;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_sent;

  logic [1:0]        w_state_nxt;
  logic              w_out_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [CNT_W-1:0]  w_sent_nxt;
  logic              w_latch;
  logic              w_ld;
  logic              w_en;
  logic              w_zero;
  logic [TIME_W-1:0] w_ld_val;
  logic [TIME_W-1:0] w_in_high_m1;
  logic [TIME_W-1:0] w_in_low_m1;

  // Phase lengths are stored as (effective length - 1), the timer's load value.
  assign w_in_high_m1 = TIME_W'(min_one(32'(high_len)) - 32'd1);
  assign w_in_low_m1  = TIME_W'(min_one(32'(low_len)) - 32'd1);

  phase_timer #(
    .TIME_W (TIME_W)
  ) u_phase_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_ld),
    .i_load_val (w_ld_val),
    .i_en       (w_en),
    .o_zero     (w_zero)
  );

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_sent_nxt  = r_sent;
    w_latch     = 1'b0;
    w_ld        = 1'b0;
    w_ld_val    = r_high_m1;
    w_en        = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_out_nxt   = 1'b0;
      w_busy_nxt  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            w_latch = 1'b1;
            if (n_pulses != '0) begin
              // Entering HIGH counts the first rising edge.
              w_state_nxt = ST_HIGH;
              w_ld        = 1'b1;
              w_ld_val    = w_in_high_m1;
              w_sent_nxt  = CNT_W'(1'b1);
              w_out_nxt   = 1'b1;
              w_busy_nxt  = 1'b1;
            end else begin
              w_state_nxt = ST_DONE;
              w_sent_nxt  = '0;
              w_done_nxt  = 1'b1;
              w_out_nxt   = 1'b0;
              w_busy_nxt  = 1'b0;
            end
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_HIGH: begin
          if (w_zero) begin
            w_state_nxt = ST_LOW;
            w_ld        = 1'b1;
            w_ld_val    = r_low_m1;
            w_out_nxt   = 1'b0;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_LOW: begin
          if (w_zero) begin
            if (r_sent < r_n) begin
              w_state_nxt = ST_HIGH;
              w_ld        = 1'b1;
              w_ld_val    = r_high_m1;
              w_sent_nxt  = r_sent + CNT_W'(1'b1);
              w_out_nxt   = 1'b1;
            end else begin
              w_state_nxt = ST_DONE;
              w_done_nxt  = 1'b1;
              w_busy_nxt  = 1'b0;
              w_out_nxt   = 1'b0;
            end
          end else begin
            w_en = 1'b1;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_out_nxt   = 1'b0;
          w_busy_nxt  = 1'b0;
        end
      endcase
    end
  end

  // Burst configuration, captured only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n       <= '0;
      r_high_m1 <= '0;
      r_low_m1  <= '0;
    end else if (w_latch) begin
      r_n       <= n_pulses;
      r_high_m1 <= w_in_high_m1;
      r_low_m1  <= w_in_low_m1;
    end
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sent  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_sent  <= w_sent_nxt;
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;
  assign sent = r_sent;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: a table of bursts checked cycle by cycle
// against hand-computed timing, plus sequences for reset, abort, start+abort,
// async reset mid-burst and a full-range count on a narrow instance.
module tb_pulse_train_gen;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] n_pulses;
  logic [15:0] high_len;
  logic [15:0] low_len;
  logic        busy;
  logic        done;
  logic        out;
  logic [15:0] sent;

  logic        start2;
  logic [7:0]  n2;
  logic [7:0]  h2;
  logic [7:0]  l2;
  logic        busy2;
  logic        done2;
  logic        out2;
  logic [7:0]  sent2;

  int n_vec;
  int n_bad;

  pulse_train_gen #(.CNT_W(16), .TIME_W(16)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .n_pulses (n_pulses),
    .high_len (high_len),
    .low_len  (low_len),
    .busy     (busy),
    .done     (done),
    .out      (out),
    .sent     (sent)
  );

  pulse_train_gen #(.CNT_W(8), .TIME_W(8)) u_dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start2),
    .abort    (abort),
    .n_pulses (n2),
    .high_len (h2),
    .low_len  (l2),
    .busy     (busy2),
    .done     (done2),
    .out      (out2),
    .sent     (sent2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int n;
    int h;
    int l;
    int h_eff;
    int period;
    int done_cyc;
    int exp_sent;
    int exp_edges;
    int exp_high;
    int exp_busy;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Present a start at the next negedge; returns at the negedge inside cycle 1.
  task automatic launch(input int n, input int h, input int l);
    @(negedge clk);
    n_pulses = 16'(n);
    high_len = 16'(h);
    low_len  = 16'(l);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    n_pulses = 16'(n) ^ 16'hFFFF;
    high_len = 16'(h) + 16'd7;
    low_len  = 16'(l) + 16'd9;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int  pat_bad;
    int  first_bad;
    int  edges;
    int  high_c;
    int  busy_c;
    int  done_first;
    int  done_cnt;
    logic prev;
    logic e_out;
    logic e_busy;
    logic e_done;
    pat_bad = 0; first_bad = 0; edges = 0; high_c = 0; busy_c = 0;
    done_first = 0; done_cnt = 0; prev = 1'b0;
    launch(v.n, v.h, v.l);
    for (int c = 1; c <= v.done_cyc + 3; c++) begin
      if (c > 1) @(negedge clk);
      e_busy = (c <= v.n * v.period);
      e_out  = e_busy && (((c - 1) % v.period) < v.h_eff);
      e_done = (c == v.done_cyc);
      if (out !== e_out || busy !== e_busy || done !== e_done) begin
        pat_bad++;
        if (first_bad == 0) first_bad = c;
      end
      if (out === 1'b1 && prev === 1'b0) edges++;
      if (out === 1'b1) high_c++;
      if (busy === 1'b1) busy_c++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_first == 0) done_first = c;
      end
      prev = out;
    end
    check($sformatf("vec%0d pattern bad cycles (first at %0d)", idx, first_bad), pat_bad, 0);
    check($sformatf("vec%0d done cycle", idx), done_first, v.done_cyc);
    check($sformatf("vec%0d done count", idx), done_cnt, 1);
    check($sformatf("vec%0d sent", idx), {16'd0, sent}, v.exp_sent);
    check($sformatf("vec%0d rising edges", idx), edges, v.exp_edges);
    check($sformatf("vec%0d high cycles", idx), high_c, v.exp_high);
    check($sformatf("vec%0d busy cycles", idx), busy_c, v.exp_busy);
  endtask

  initial begin
    int   bad;
    int   cnt;
    int   edges;
    int   done_first;
    int   wraps;
    logic prev;
    logic [7:0] prev_sent;
    logic e_out;

    n_vec = 0; n_bad = 0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    n_pulses = 16'd3; high_len = 16'd2; low_len = 16'd3;
    start2 = 1'b0; n2 = 8'd0; h2 = 8'd0; l2 = 8'd0;

    //                n  h  l  heff per done sent edg high busy
    tbl[0] = '{n:3, h:2, l:3, h_eff:2, period:5, done_cyc:16, exp_sent:3, exp_edges:3, exp_high:6,  exp_busy:15};
    tbl[1] = '{n:2, h:0, l:0, h_eff:1, period:2, done_cyc:5,  exp_sent:2, exp_edges:2, exp_high:2,  exp_busy:4};
    tbl[2] = '{n:0, h:5, l:5, h_eff:5, period:10,done_cyc:1,  exp_sent:0, exp_edges:0, exp_high:0,  exp_busy:0};
    tbl[3] = '{n:1, h:1, l:1, h_eff:1, period:2, done_cyc:3,  exp_sent:1, exp_edges:1, exp_high:1,  exp_busy:2};
    tbl[4] = '{n:4, h:3, l:1, h_eff:3, period:4, done_cyc:17, exp_sent:4, exp_edges:4, exp_high:12, exp_busy:16};
    tbl[5] = '{n:2, h:1, l:5, h_eff:1, period:6, done_cyc:13, exp_sent:2, exp_edges:2, exp_high:2,  exp_busy:12};

    // Reset held for 10 cycles while start toggles.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("reset out/busy/done", {29'd0, out, busy, done}, 32'd0);
      check("reset sent", {16'd0, sent}, 32'd0);
      start = ~start;
    end
    check("reset small sent/out", {23'd0, sent2, out2}, 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-reset busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_vec(tbl[i], i);
    end

    // Abort mid-burst; a second start during the burst must be ignored.
    launch(5, 4, 4);
    bad = 0; cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c > 1) @(negedge clk);
      if (c <= 10) begin
        e_out = (((c - 1) % 8) < 4);
        if (out !== e_out || busy !== 1'b1 || sent !== ((c <= 8) ? 16'd1 : 16'd2)) bad++;
      end else begin
        if (out !== 1'b0 || busy !== 1'b0 || sent !== 16'd2) bad++;
      end
      if (done === 1'b1) cnt++;
      if (c == 11) check("abort out next cycle", {31'd0, out}, 32'd0);
      start = (c == 8);
      if (c == 8) n_pulses = 16'd1;
      abort = (c == 10);
    end
    check("abort sequence bad cycles", bad, 0);
    check("abort done strobes", cnt, 0);
    check("abort sent held", {16'd0, sent}, 32'd2);

    // Start and abort together in IDLE: no burst.
    @(negedge clk);
    start = 1'b1; abort = 1'b1; n_pulses = 16'd3; high_len = 16'd1; low_len = 16'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      if (out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || sent !== 16'd2) bad++;
      @(negedge clk);
    end
    check("start+abort bad cycles", bad, 0);

    // Async reset mid-burst: out drops at once, no done afterwards.
    launch(3, 2, 3);
    check("pre-reset out high", {31'd0, out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out/busy", {30'd0, out, busy}, 32'd0);
    check("async reset sent", {16'd0, sent}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("after async reset done/busy cycles", cnt, 0);

    // Full-range count on the 8-bit instance: 255 pulses, H=L=1.
    @(negedge clk);
    n2 = 8'd255; h2 = 8'd1; l2 = 8'd1; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0; n2 = 8'd3;
    edges = 0; done_first = 0; wraps = 0; prev = 1'b0; prev_sent = 8'd0;
    for (int c = 1; c <= 515; c++) begin
      if (c > 1) @(negedge clk);
      if (out2 === 1'b1 && prev === 1'b0) edges++;
      if (done2 === 1'b1 && done_first == 0) done_first = c;
      if (sent2 < prev_sent) wraps++;
      if (c == 510) check("small busy before end", {31'd0, busy2}, 32'd1);
      prev = out2;
      prev_sent = sent2;
    end
    check("small done cycle", done_first, 511);
    check("small rising edges", edges, 255);
    check("small sent final", {24'd0, sent2}, 32'd255);
    check("small sent wraps", wraps, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
